mix_vga_ramp_control: RTL and testbench



---
 rtl/mix_vga_ramp_control.sv | 181 ++++++++++++++++++
 tb/tb_mix_vga_ramp_control.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mix_vga_ramp_control.sv
// mix_vga_ramp_control: multi-channel slew-limited level -> thermometer encoder.
// Optional build macro MIX_VGA_INSTANT_EN: targets load directly, no ramp.

module mix_vga_ramp_lane #(
    parameter int LEVEL_W = 3,
    parameter int OUT_W   = 6,
    parameter int CUR_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [LEVEL_W-1:0] level,
    output logic [OUT_W-1:0]   therm,
    output logic               match,
    output logic               settle
);
    localparam int CMP_W = (LEVEL_W > CUR_W) ? LEVEL_W : CUR_W;

    logic [CMP_W-1:0] lvl_ext;
    logic [CUR_W-1:0] tgt_c;
    logic [CUR_W-1:0] cur;
    logic [CUR_W-1:0] cur_nxt;
    logic [OUT_W-1:0] therm_nxt;

    always_comb begin
        lvl_ext = CMP_W'(level);
        tgt_c   = (lvl_ext > CMP_W'(OUT_W)) ? CUR_W'(OUT_W) : CUR_W'(lvl_ext);
    end

    assign match = (tgt_c == cur);

`ifdef MIX_VGA_INSTANT_EN
    logic unused_step;
    assign unused_step = step;
    assign settle      = 1'b1;

    always_comb begin
        cur_nxt = load ? tgt_c : cur;
    end
`else
    logic [CUR_W-1:0] tgt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      tgt <= '0;
        else if (load) tgt <= tgt_c;
    end

    // Load and step never coincide: load only happens in IDLE, step only in RAMP.
    always_comb begin
        cur_nxt = cur;
        if (step && (cur != tgt))
            cur_nxt = (tgt > cur) ? cur + CUR_W'(1) : cur - CUR_W'(1);
    end

    assign settle = (cur_nxt == tgt);
`endif

    always_comb begin
        therm_nxt = '0;
        for (int i = 0; i < OUT_W; i++)
            therm_nxt[i] = (i < int'(cur_nxt));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur   <= '0;
            therm <= '0;
        end else begin
            cur   <= cur_nxt;
            therm <= therm_nxt;
        end
    end
endmodule

module mix_vga_ramp_control #(
    parameter int NUM_CH   = 2,
    parameter int LEVEL_W  = 3,
    parameter int OUT_W    = 6,
    parameter int STEP_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      gnd,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_CH*LEVEL_W-1:0] level_in,
    output logic [NUM_CH*OUT_W-1:0]   therm_out,
    output logic                      busy,
    output logic                      done
);
    localparam int CUR_W = $clog2(OUT_W + 1);

    typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

    state_t                           state_q, state_d;
    logic                             accept;
    logic                             step;
    logic [NUM_CH-1:0]                match;
    logic [NUM_CH-1:0]                settle;
    logic [NUM_CH-1:0][LEVEL_W-1:0]   lvl;
    logic [NUM_CH-1:0][OUT_W-1:0]     therm;

    logic unused_gnd;
    assign unused_gnd = gnd;

    assign lvl       = level_in;
    assign therm_out = therm;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        mix_vga_ramp_lane #(
            .LEVEL_W (LEVEL_W),
            .OUT_W   (OUT_W),
            .CUR_W   (CUR_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .load   (accept),
            .step   (step),
            .level  (lvl[c]),
            .therm  (therm[c]),
            .match  (match[c]),
            .settle (settle[c])
        );
    end

`ifdef MIX_VGA_INSTANT_EN
    logic unused_sts;
    assign unused_sts = ^{match, settle};
`else
    localparam int              DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                div_cnt <= '0;
        else if (accept)         div_cnt <= '0;
        else if (state_q == RAMP) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
`ifdef MIX_VGA_INSTANT_EN
                    state_d = DONE;
`else
                    state_d = (&match) ? DONE : RAMP;
`endif
                end
            end
`ifndef MIX_VGA_INSTANT_EN
            RAMP: begin
                busy = 1'b1;
                step = (div_cnt == DIV_LAST);
                if (step && (&settle)) state_d = DONE;
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mix_vga_ramp_control.sv
// Directed bench for mix_vga_ramp_control with default parameters (2 ch, 3-bit level, 6-bit therm, div 4).

module tb_mix_vga_ramp_control;
    logic        clk = 1'b0;
    logic        rst;
    logic        gnd;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  level_in;
    logic [11:0] therm_out;
    logic        busy;
    logic        done;

    int passed = 0;
    int total  = 0;
    int dcnt   = 0;

    mix_vga_ramp_control dut (
        .clk       (clk),
        .rst       (rst),
        .gnd       (gnd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .level_in  (level_in),
        .therm_out (therm_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (done) dcnt++;
        end
    endtask

    // Present a target set for one edge; returns at the negedge after the accept edge.
    task automatic send(input logic [2:0] l0, input logic [2:0] l1);
        level_in = {l1, l0};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; gnd = 1'b0; in_valid = 1'b0; level_in = '0;
        #3;
        chk("rst_therm", 32'(therm_out), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_done",  32'(done), 32'h0);
        cyc(2);
        rst = 1'b1;
        cyc(1);

        // single step ch0 0->1
        send(3'd1, 3'd0);
        chk("s1_busy",  32'(busy), 32'h1);
        chk("s1_ready", 32'(in_ready), 32'h0);
        cyc(3);
        chk("s1_e3_therm", 32'(therm_out), 32'h0);
        cyc(1);
        chk("s1_e4_therm", 32'(therm_out), 32'b000000_000001);
        chk("s1_e4_done",  32'(done), 32'h1);
        cyc(1);
        chk("s1_idle_done",  32'(done), 32'h0);
        chk("s1_idle_ready", 32'(in_ready), 32'h1);

        // back to zero for the dual-channel ramp
        rst = 1'b0;
        #1;
        chk("rst2_therm", 32'(therm_out), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1);

        // ch0 0->6, ch1 0->2, with an in_valid pulse mid-ramp that must be ignored
        dcnt = 0;
        send(3'd6, 3'd2);
        cyc(8);
        chk("r_e8",  32'(therm_out), 32'b000011_000011);
        cyc(8);
        chk("r_e16", 32'(therm_out), 32'b000011_001111);
        level_in = 6'd0;
        in_valid = 1'b1;
        cyc(1);
        chk("r_ign_ready", 32'(in_ready), 32'h0);
        chk("r_ign_busy",  32'(busy), 32'h1);
        in_valid = 1'b0;
        level_in = {3'd2, 3'd6};
        cyc(6);
        chk("r_e23_therm", 32'(therm_out), 32'b000011_011111);
        chk("r_e23_done",  32'(done), 32'h0);
        cyc(1);
        chk("r_e24_therm", 32'(therm_out), 32'b000011_111111);
        chk("r_e24_done",  32'(done), 32'h1);
        cyc(1);
        chk("r_idle_ready", 32'(in_ready), 32'h1);
        chk("r_done_once",  32'(dcnt), 32'h1);

        // level 7 clamps to 6 == cur: no-change accept, held valid re-accepts
        level_in = {3'd2, 3'd7};
        in_valid = 1'b1;
        @(negedge clk);
        chk("nc_done",  32'(done), 32'h1);
        chk("nc_busy",  32'(busy), 32'h0);
        chk("nc_therm", 32'(therm_out), 32'b000011_111111);
        @(negedge clk);
        chk("nc_idle_ready", 32'(in_ready), 32'h1);
        chk("nc_idle_done",  32'(done), 32'h0);
        @(negedge clk);
        chk("nc_reaccept_done", 32'(done), 32'h1);
        in_valid = 1'b0;
        cyc(1);

        // ramp ch0 down 6->0
        send(3'd0, 3'd2);
        cyc(4);
        chk("dn_e4", 32'(therm_out), 32'b000011_011111);
        cyc(4);
        chk("dn_e8", 32'(therm_out), 32'b000011_001111);
        cyc(16);
        chk("dn_e24_therm", 32'(therm_out), 32'b000011_000000);
        chk("dn_e24_done",  32'(done), 32'h1);
        cyc(1);

        // ramp up to clamped 7 -> stops at 6 after exactly 24 edges
        send(3'd7, 3'd2);
        cyc(23);
        chk("cl_e23_done", 32'(done), 32'h0);
        cyc(1);
        chk("cl_e24_therm", 32'(therm_out), 32'b000011_111111);
        chk("cl_e24_done",  32'(done), 32'h1);
        cyc(1);

        // async reset mid-ramp at cur=3
        send(3'd0, 3'd2);
        cyc(12);
        chk("mr_e12_therm", 32'(therm_out), 32'b000011_000111);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_therm", 32'(therm_out), 32'h0);
        chk("mr_busy",  32'(busy), 32'h0);
        chk("mr_ready", 32'(in_ready), 32'h1);
        chk("mr_done",  32'(done), 32'h0);
        dcnt = 0;
        cyc(3);
        rst = 1'b1;
        cyc(12);
        chk("mr_no_done",   32'(dcnt), 32'h0);
        chk("mr_therm_end", 32'(therm_out), 32'h0);
        chk("mr_ready_end", 32'(in_ready), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
